// File: rtl/hw_rot_if.sv
// Access-check bundle between SoC masters and the hw_rot policy checker.
// Request in cycle t yields a registered response in cycle t+1.
interface hw_rot_if;
   logic        req_valid;
   logic [3:0]  req_mid;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_allow;

   modport master (
      output req_valid, req_mid, req_write, req_addr, req_wdata,
      input  resp_valid, resp_allow
   );

   modport slave (
      input  req_valid, req_mid, req_write, req_addr, req_wdata,
      output resp_valid, resp_allow
   );
endinterface

// File: rtl/hw_rot.sv
// Root-of-trust policy block: UART-programmed APU/DPU register file,
// single-cycle access checker and core reset release.
module hw_rot #(
   parameter int NUM_APU_POLICY = 8,
   parameter int NUM_DPU_POLICY = 8,
   parameter int CLKS_PER_BIT   = 10
) (
   input  logic    CLK,
   input  logic    PORESET,
   input  logic    NRESET,
   input  logic    UART_RX,
   output logic    UART_TX,
   output logic    core_rst_n,
   hw_rot_if.slave bus
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF    = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [31:0] APU_BASE  = 32'h4002_0000;
   localparam logic [31:0] DPU_BASE  = 32'h4002_0100;
   localparam logic [7:0]  OP_WR     = 8'h57;
   localparam logic [7:0]  OP_RD     = 8'h52;
   localparam logic [7:0]  ACK       = 8'h06;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE, TX_START, TX_DATA, TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      C_IDLE, C_ADDR, C_DATA, C_EXEC, C_RESP
   } cmd_state_t;

   function automatic logic [31:0] apu_reg(input int n, input int off);
      return APU_BASE + 32'(n * 16 + off);
   endfunction

   function automatic logic [31:0] dpu_reg(input int n, input int off);
      return DPU_BASE + 32'(n * 32 + off);
   endfunction

   // UART receive
   rx_state_t     r_rx_st, w_rx_nx;
   logic          r_rx_s1, r_rx_s2;
   logic [CW-1:0] r_rx_cnt;
   logic [2:0]    r_rx_bit;
   logic [7:0]    r_rx_sh;
   logic          r_rx_valid, r_rx_ferr;
   logic          w_rx_tick;

   // UART transmit
   tx_state_t     r_tx_st, w_tx_nx;
   logic [CW-1:0] r_tx_cnt;
   logic [2:0]    r_tx_bit;
   logic [7:0]    r_tx_sh;
   logic          w_tx_tick, w_tx_busy, w_tx_start;
   logic [7:0]    w_tx_byte;

   // Command sequencer
   cmd_state_t    r_cmd_st, w_cmd_nx;
   logic          r_op_wr;
   logic [1:0]    r_byte_cnt;
   logic [31:0]   r_addr, r_wdata, r_rdata;
   logic [2:0]    r_resp_left;
   logic          w_last, w_reg_we;
   logic [31:0]   w_word, w_rd_data;

   // Policy storage
   logic [3:0]    r_apu_mid   [NUM_APU_POLICY];
   logic [31:0]   r_apu_addr  [NUM_APU_POLICY];
   logic [31:0]   r_apu_mask  [NUM_APU_POLICY];
   logic [1:0]    r_apu_perm  [NUM_APU_POLICY];
   logic [3:0]    r_dpu_mid   [NUM_DPU_POLICY];
   logic [31:0]   r_dpu_addr  [NUM_DPU_POLICY];
   logic [31:0]   r_dpu_data  [NUM_DPU_POLICY];
   logic [31:0]   r_dpu_mask  [NUM_DPU_POLICY];
   logic [31:0]   r_dpu_amask [NUM_DPU_POLICY];

   logic          w_apu_en, w_apu_match, w_dpu_hit, w_allow;
   logic          r_resp_valid, r_resp_allow, r_core_rst_n;

   assign w_rx_tick = (r_rx_cnt == BIT_END);

   always_comb begin
      w_rx_nx = r_rx_st;
      unique case (r_rx_st)
         RX_IDLE:  if (!r_rx_s2) w_rx_nx = RX_START;
         RX_START: if (r_rx_cnt == HALF)
                      w_rx_nx = r_rx_s2 ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7)
                      w_rx_nx = RX_STOP;
         RX_STOP:  if (w_rx_tick)
                      w_rx_nx = r_rx_s2 ? RX_IDLE : RX_BREAK;
         RX_BREAK: if (r_rx_s2) w_rx_nx = RX_IDLE;
         default:  w_rx_nx = RX_IDLE;
      endcase
   end

   // A framing error parks the receiver until the line idles high again
   always_ff @(posedge CLK) begin
      if (PORESET) begin
         r_rx_s1    <= 1'b1;
         r_rx_s2    <= 1'b1;
         r_rx_st    <= RX_IDLE;
         r_rx_cnt   <= '0;
         r_rx_bit   <= '0;
         r_rx_sh    <= '0;
         r_rx_valid <= 1'b0;
         r_rx_ferr  <= 1'b0;
      end else begin
         r_rx_s1    <= UART_RX;
         r_rx_s2    <= r_rx_s1;
         r_rx_st    <= w_rx_nx;
         r_rx_valid <= 1'b0;
         r_rx_ferr  <= 1'b0;
         if (r_rx_st != w_rx_nx || w_rx_tick)
            r_rx_cnt <= '0;
         else
            r_rx_cnt <= r_rx_cnt + 1'b1;
         if (r_rx_st == RX_START)
            r_rx_bit <= '0;
         if (r_rx_st == RX_DATA && w_rx_tick) begin
            r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
            r_rx_bit <= r_rx_bit + 1'b1;
         end
         if (r_rx_st == RX_STOP && w_rx_tick) begin
            r_rx_valid <= r_rx_s2;
            r_rx_ferr  <= !r_rx_s2;
         end
      end
   end

   assign w_tx_tick = (r_tx_cnt == BIT_END);
   assign w_tx_busy = (r_tx_st != TX_IDLE);

   always_comb begin
      w_tx_nx = r_tx_st;
      unique case (r_tx_st)
         TX_IDLE:  if (w_tx_start) w_tx_nx = TX_START;
         TX_START: if (w_tx_tick) w_tx_nx = TX_DATA;
         TX_DATA:  if (w_tx_tick && r_tx_bit == 3'd7)
                      w_tx_nx = TX_STOP;
         TX_STOP:  if (w_tx_tick) w_tx_nx = TX_IDLE;
         default:  w_tx_nx = TX_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (PORESET) begin
         r_tx_st  <= TX_IDLE;
         r_tx_cnt <= '0;
         r_tx_bit <= '0;
         r_tx_sh  <= '0;
      end else begin
         r_tx_st <= w_tx_nx;
         if (r_tx_st == TX_IDLE || w_tx_tick)
            r_tx_cnt <= '0;
         else
            r_tx_cnt <= r_tx_cnt + 1'b1;
         if (r_tx_st == TX_IDLE) begin
            r_tx_sh  <= w_tx_byte;
            r_tx_bit <= '0;
         end
         if (r_tx_st == TX_DATA && w_tx_tick) begin
            r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
            r_tx_bit <= r_tx_bit + 1'b1;
         end
      end
   end

   assign UART_TX = (r_tx_st == TX_START) ? 1'b0 :
                    (r_tx_st == TX_DATA)  ? r_tx_sh[0] : 1'b1;

   assign w_last = r_rx_valid && (r_byte_cnt == 2'd3);
   assign w_word = r_addr & 32'hFFFF_FFFC;

   always_comb begin
      w_cmd_nx   = r_cmd_st;
      w_reg_we   = 1'b0;
      w_tx_start = 1'b0;
      w_tx_byte  = r_op_wr ? ACK : r_rdata[31:24];
      unique case (r_cmd_st)
         C_IDLE:
            if (r_rx_valid && (r_rx_sh == OP_WR || r_rx_sh == OP_RD))
               w_cmd_nx = C_ADDR;
         C_ADDR:
            if (r_rx_ferr)
               w_cmd_nx = C_IDLE;
            else if (w_last)
               w_cmd_nx = r_op_wr ? C_DATA : C_EXEC;
         C_DATA:
            if (r_rx_ferr)
               w_cmd_nx = C_IDLE;
            else if (w_last)
               w_cmd_nx = C_EXEC;
         C_EXEC: begin
            w_reg_we = r_op_wr;
            w_cmd_nx = C_RESP;
         end
         C_RESP:
            if (!w_tx_busy) begin
               if (r_resp_left != 3'd0)
                  w_tx_start = 1'b1;
               else
                  w_cmd_nx = C_IDLE;
            end
         default: w_cmd_nx = C_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (PORESET) begin
         r_cmd_st    <= C_IDLE;
         r_op_wr     <= 1'b0;
         r_byte_cnt  <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rdata     <= '0;
         r_resp_left <= '0;
      end else begin
         r_cmd_st <= w_cmd_nx;
         case (r_cmd_st)
            C_IDLE:
               if (r_rx_valid) begin
                  r_op_wr    <= (r_rx_sh == OP_WR);
                  r_byte_cnt <= '0;
               end
            C_ADDR:
               if (r_rx_valid) begin
                  r_addr     <= {r_addr[23:0], r_rx_sh};
                  r_byte_cnt <= r_byte_cnt + 1'b1;
               end
            C_DATA:
               if (r_rx_valid) begin
                  r_wdata    <= {r_wdata[23:0], r_rx_sh};
                  r_byte_cnt <= r_byte_cnt + 1'b1;
               end
            C_EXEC: begin
               r_rdata     <= w_rd_data;
               r_resp_left <= r_op_wr ? 3'd1 : 3'd4;
            end
            C_RESP:
               if (w_tx_start) begin
                  r_resp_left <= r_resp_left - 1'b1;
                  r_rdata     <= {r_rdata[23:0], 8'h00};
               end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (PORESET) begin
         for (int n = 0; n < NUM_APU_POLICY; n++) begin
            r_apu_mid[n]  <= '0;
            r_apu_addr[n] <= '0;
            r_apu_mask[n] <= '0;
            r_apu_perm[n] <= '0;
         end
         for (int n = 0; n < NUM_DPU_POLICY; n++) begin
            r_dpu_mid[n]   <= '0;
            r_dpu_addr[n]  <= '0;
            r_dpu_data[n]  <= '0;
            r_dpu_mask[n]  <= '0;
            r_dpu_amask[n] <= '0;
         end
      end else if (w_reg_we) begin
         for (int n = 0; n < NUM_APU_POLICY; n++) begin
            if (w_word == apu_reg(n, 0))
               r_apu_mid[n] <= r_wdata[3:0];
            if (w_word == apu_reg(n, 4))
               r_apu_addr[n] <= r_wdata;
            if (w_word == apu_reg(n, 8))
               r_apu_mask[n] <= r_wdata;
            if (w_word == apu_reg(n, 12))
               r_apu_perm[n] <= r_wdata[1:0];
         end
         for (int n = 0; n < NUM_DPU_POLICY; n++) begin
            if (w_word == dpu_reg(n, 0))
               r_dpu_mid[n] <= r_wdata[3:0];
            if (w_word == dpu_reg(n, 4))
               r_dpu_addr[n] <= r_wdata;
            if (w_word == dpu_reg(n, 8))
               r_dpu_data[n] <= r_wdata;
            if (w_word == dpu_reg(n, 12))
               r_dpu_mask[n] <= r_wdata;
            if (w_word == dpu_reg(n, 16))
               r_dpu_amask[n] <= r_wdata;
         end
      end
   end

   always_comb begin
      w_rd_data = '0;
      for (int n = 0; n < NUM_APU_POLICY; n++) begin
         if (w_word == apu_reg(n, 0))
            w_rd_data = {28'd0, r_apu_mid[n]};
         if (w_word == apu_reg(n, 4))
            w_rd_data = r_apu_addr[n];
         if (w_word == apu_reg(n, 8))
            w_rd_data = r_apu_mask[n];
         if (w_word == apu_reg(n, 12))
            w_rd_data = {30'd0, r_apu_perm[n]};
      end
      for (int n = 0; n < NUM_DPU_POLICY; n++) begin
         if (w_word == dpu_reg(n, 0))
            w_rd_data = {28'd0, r_dpu_mid[n]};
         if (w_word == dpu_reg(n, 4))
            w_rd_data = r_dpu_addr[n];
         if (w_word == dpu_reg(n, 8))
            w_rd_data = r_dpu_data[n];
         if (w_word == dpu_reg(n, 12))
            w_rd_data = r_dpu_mask[n];
         if (w_word == dpu_reg(n, 16))
            w_rd_data = r_dpu_amask[n];
      end
   end

   // Mask bits set to 1 are don't-care in both address and data compares
   always_comb begin
      w_apu_en    = 1'b0;
      w_apu_match = 1'b0;
      w_dpu_hit   = 1'b0;
      for (int n = 0; n < NUM_APU_POLICY; n++) begin
         if (r_apu_perm[n] != 2'd0) begin
            w_apu_en = 1'b1;
            if (bus.req_mid == r_apu_mid[n] &&
                ((bus.req_addr ^ r_apu_addr[n]) & ~r_apu_mask[n]) == 32'd0 &&
                (bus.req_write ? r_apu_perm[n][1] : r_apu_perm[n][0]))
               w_apu_match = 1'b1;
         end
      end
      for (int n = 0; n < NUM_DPU_POLICY; n++) begin
         if (r_dpu_mid[n] != 4'd0 && bus.req_write &&
             bus.req_mid == r_dpu_mid[n] &&
             ((bus.req_addr ^ r_dpu_addr[n]) & ~r_dpu_amask[n]) == 32'd0 &&
             ((bus.req_wdata ^ r_dpu_data[n]) & ~r_dpu_mask[n]) == 32'd0)
            w_dpu_hit = 1'b1;
      end
      w_allow = (!w_apu_en || w_apu_match) && !w_dpu_hit;
   end

   always_ff @(posedge CLK) begin
      if (PORESET) begin
         r_resp_valid <= 1'b0;
         r_resp_allow <= 1'b0;
         r_core_rst_n <= 1'b0;
      end else begin
         r_resp_valid <= bus.req_valid;
         r_resp_allow <= bus.req_valid && w_allow;
         r_core_rst_n <= NRESET;
      end
   end

   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_allow = r_resp_allow;
   assign core_rst_n     = r_core_rst_n;

endmodule

// File: tb/tb_hw_rot.sv
// Scoreboard bench for hw_rot: UART host programming plus access checks.
module tb_hw_rot;
   localparam int CPB = 10;

   logic clk = 1'b0;
   logic PORESET, NRESET, UART_RX, UART_TX, core_rst_n;

   hw_rot_if bus_if();

   hw_rot #(
      .NUM_APU_POLICY(8),
      .NUM_DPU_POLICY(8),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .CLK(clk),
      .PORESET(PORESET),
      .NRESET(NRESET),
      .UART_RX(UART_RX),
      .UART_TX(UART_TX),
      .core_rst_n(core_rst_n),
      .bus(bus_if)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int tx_seen = 0;
   logic [7:0] exp_tx_q[$];
   logic       exp_resp_q[$];

   // UART byte monitor: samples mid-bit and checks against the scoreboard
   initial begin : uart_mon
      logic [7:0] b;
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (UART_TX === 1'b0 && PORESET === 1'b0) begin
            repeat (CPB / 2 - 1) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = UART_TX;
            end
            repeat (CPB) @(negedge clk);
            tx_seen++;
            total++;
            if (exp_tx_q.size() == 0) begin
               bad++;
               $display("FAIL uart_unexpected: got %02h required none", b);
            end else begin
               e = exp_tx_q.pop_front();
               if (b !== e || UART_TX !== 1'b1) begin
                  bad++;
                  $display("FAIL uart_byte: got %02h stop=%b required %02h stop=1",
                           b, UART_TX, e);
               end
            end
         end
      end
   end

   initial begin : resp_mon
      logic e;
      forever begin
         @(negedge clk);
         if (bus_if.resp_valid === 1'b1) begin
            total++;
            if (exp_resp_q.size() == 0) begin
               bad++;
               $display("FAIL resp_unexpected: got valid=1 required 0");
            end else begin
               e = exp_resp_q.pop_front();
               if (bus_if.resp_allow !== e) begin
                  bad++;
                  $display("FAIL resp_allow: got %b required %b",
                           bus_if.resp_allow, e);
               end
            end
         end
      end
   end

   task automatic uart_byte(input logic [7:0] b, input logic stop);
      UART_RX = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         UART_RX = b[i];
         repeat (CPB) @(negedge clk);
      end
      UART_RX = stop;
      repeat (CPB) @(negedge clk);
      UART_RX = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic wait_tx_drain(input string name);
      int n;
      n = 0;
      while (exp_tx_q.size() != 0 && n < 1500) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (exp_tx_q.size() != 0) begin
         bad++;
         $display("FAIL %s: %0d bytes missing, required 0", name, exp_tx_q.size());
         exp_tx_q.delete();
      end
      repeat (20) @(negedge clk);
   endtask

   task automatic host_write(input logic [31:0] a, input logic [31:0] d);
      exp_tx_q.push_back(8'h06);
      uart_byte(8'h57, 1'b1);
      for (int i = 3; i >= 0; i--) uart_byte(a[i*8 +: 8], 1'b1);
      for (int i = 3; i >= 0; i--) uart_byte(d[i*8 +: 8], 1'b1);
      wait_tx_drain("write_ack");
   endtask

   task automatic host_read(input logic [31:0] a, input logic [31:0] d);
      for (int i = 3; i >= 0; i--) exp_tx_q.push_back(d[i*8 +: 8]);
      uart_byte(8'h52, 1'b1);
      for (int i = 3; i >= 0; i--) uart_byte(a[i*8 +: 8], 1'b1);
      wait_tx_drain("read_data");
   endtask

   task automatic drive_req(input logic [3:0] mid, input logic wr,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic exp);
      bus_if.req_valid = 1'b1;
      bus_if.req_mid   = mid;
      bus_if.req_write = wr;
      bus_if.req_addr  = a;
      bus_if.req_wdata = d;
      exp_resp_q.push_back(exp);
      @(negedge clk);
      bus_if.req_valid = 1'b0;
   endtask

   task automatic wait_resp_drain();
      int n;
      n = 0;
      while (exp_resp_q.size() != 0 && n < 5) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (exp_resp_q.size() != 0) begin
         bad++;
         $display("FAIL resp_timeout: %0d pending, required 0", exp_resp_q.size());
         exp_resp_q.delete();
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total += 4;
      if (UART_TX !== 1'b1) begin
         bad++; $display("FAIL rst_tx: got %b required 1", UART_TX);
      end
      if (core_rst_n !== 1'b0) begin
         bad++; $display("FAIL rst_core: got %b required 0", core_rst_n);
      end
      if (bus_if.resp_valid !== 1'b0) begin
         bad++; $display("FAIL rst_valid: got %b required 0", bus_if.resp_valid);
      end
      if (bus_if.resp_allow !== 1'b0) begin
         bad++; $display("FAIL rst_allow: got %b required 0", bus_if.resp_allow);
      end
   endtask

   task automatic test_core_release();
      PORESET = 1'b0;
      repeat (4) @(negedge clk);
      total++;
      if (core_rst_n !== 1'b0) begin
         bad++; $display("FAIL core_hold: got %b required 0", core_rst_n);
      end
      NRESET = 1'b1;
      #1;
      total++;
      if (core_rst_n !== 1'b0) begin
         bad++; $display("FAIL core_early: got %b required 0", core_rst_n);
      end
      @(negedge clk);
      total++;
      if (core_rst_n !== 1'b1) begin
         bad++; $display("FAIL core_release: got %b required 1", core_rst_n);
      end
   endtask

   task automatic test_readback();
      host_write(32'h4002_0004, 32'h2000_0000);
      host_read(32'h4002_0004, 32'h2000_0000);
      host_write(32'h2000_0080, 32'h1234_5678);
      host_read(32'h2000_0080, 32'h0000_0000);
      host_write(32'h4002_0100, 32'hFFFF_FFFF);
      host_read(32'h4002_0100, 32'h0000_000F);
      host_write(32'h4002_0100, 32'h0000_0000);
      host_write(32'h4002_001C, 32'hFFFF_FFFF);
      host_read(32'h4002_001F, 32'h0000_0003);
      host_write(32'h4002_001C, 32'h0000_0000);
   endtask

   task automatic test_default();
      drive_req(4'd5, 1'b1, 32'h1234_5678, 32'h0, 1'b1);
      drive_req(4'd0, 1'b0, 32'h0000_0000, 32'h0, 1'b1);
      drive_req(4'd15, 1'b1, 32'hFFFF_FFFC, 32'h0BAD_BEEF, 1'b1);
      wait_resp_drain();
   endtask

   task automatic test_apu();
      host_write(32'h4002_0000, 32'h0000_0002);
      host_write(32'h4002_0008, 32'h0001_FFFF);
      host_write(32'h4002_000C, 32'h0000_0003);
      drive_req(4'd2, 1'b0, 32'h2001_FFFC, 32'h0, 1'b1);
      drive_req(4'd2, 1'b0, 32'h2002_0000, 32'h0, 1'b0);
      drive_req(4'd3, 1'b0, 32'h2000_0000, 32'h0, 1'b0);
      drive_req(4'd2, 1'b1, 32'h2000_0000, 32'h0, 1'b1);
      wait_resp_drain();
   endtask

   task automatic test_perm();
      host_write(32'h4002_0020, 32'h0000_0002);
      host_write(32'h4002_0024, 32'h4002_0000);
      host_write(32'h4002_0028, 32'h0000_FFFF);
      host_write(32'h4002_002C, 32'h0000_0001);
      drive_req(4'd2, 1'b1, 32'h4002_0010, 32'h0, 1'b0);
      drive_req(4'd2, 1'b0, 32'h4002_0010, 32'h0, 1'b1);
      wait_resp_drain();
   endtask

   task automatic test_dpu();
      host_write(32'h4002_0124, 32'h2000_FFFC);
      host_write(32'h4002_0128, 32'h0BAD_BEEF);
      host_write(32'h4002_012C, 32'h0000_0000);
      host_write(32'h4002_0130, 32'h0FFF_FFFF);
      host_write(32'h4002_0120, 32'h0000_0002);
      drive_req(4'd2, 1'b1, 32'h2000_0100, 32'h0BAD_BEEF, 1'b0);
      drive_req(4'd2, 1'b1, 32'h2000_0100, 32'h0BAD_BEEE, 1'b1);
      drive_req(4'd3, 1'b1, 32'h2000_0100, 32'h0BAD_BEEF, 1'b0);
      drive_req(4'd2, 1'b0, 32'h2000_0100, 32'h0BAD_BEEF, 1'b1);
      wait_resp_drain();
   endtask

   task automatic test_back_to_back();
      drive_req(4'd2, 1'b0, 32'h2001_FFFC, 32'h0, 1'b1);
      drive_req(4'd2, 1'b0, 32'h2002_0000, 32'h0, 1'b0);
      drive_req(4'd2, 1'b1, 32'h2000_0100, 32'h0BAD_BEEF, 1'b0);
      drive_req(4'd2, 1'b1, 32'h2000_0100, 32'h0BAD_BEEE, 1'b1);
      drive_req(4'd3, 1'b0, 32'h2000_0000, 32'h0, 1'b0);
      drive_req(4'd2, 1'b0, 32'h4002_0010, 32'h0, 1'b1);
      wait_resp_drain();
   endtask

   task automatic test_uart_robust();
      int seen;
      seen = tx_seen;
      uart_byte(8'h57, 1'b1);
      uart_byte(8'h40, 1'b1);
      uart_byte(8'h02, 1'b1);
      uart_byte(8'h00, 1'b1);
      uart_byte(8'h04, 1'b1);
      uart_byte(8'h11, 1'b0);
      uart_byte(8'h22, 1'b1);
      uart_byte(8'h33, 1'b1);
      uart_byte(8'h44, 1'b1);
      repeat (300) @(negedge clk);
      total++;
      if (tx_seen !== seen) begin
         bad++;
         $display("FAIL bad_stop_resp: got %0d bytes required 0", tx_seen - seen);
      end
      host_read(32'h4002_0004, 32'h2000_0000);
      uart_byte(8'h41, 1'b1);
      host_write(32'h4002_0034, 32'hCAFE_F00D);
      host_read(32'h4002_0034, 32'hCAFE_F00D);
   endtask

   task automatic test_poreset();
      uart_byte(8'h57, 1'b1);
      uart_byte(8'h40, 1'b1);
      UART_RX = 1'b0;
      repeat (15) @(negedge clk);
      PORESET = 1'b1;
      UART_RX = 1'b1;
      @(negedge clk);
      total++;
      if (core_rst_n !== 1'b0) begin
         bad++; $display("FAIL por_core: got %b required 0", core_rst_n);
      end
      repeat (4) @(negedge clk);
      PORESET = 1'b0;
      @(negedge clk);
      total++;
      if (core_rst_n !== 1'b1) begin
         bad++; $display("FAIL por_release: got %b required 1", core_rst_n);
      end
      host_read(32'h4002_0004, 32'h0000_0000);
      host_read(32'h4002_000C, 32'h0000_0000);
      host_read(32'h4002_0120, 32'h0000_0000);
      host_read(32'h4002_0128, 32'h0000_0000);
      drive_req(4'd3, 1'b0, 32'h2000_0000, 32'h0, 1'b1);
      drive_req(4'd2, 1'b1, 32'h2000_0100, 32'h0BAD_BEEF, 1'b1);
      wait_resp_drain();
   endtask

   initial begin
      PORESET          = 1'b1;
      NRESET           = 1'b0;
      UART_RX          = 1'b1;
      bus_if.req_valid = 1'b0;
      bus_if.req_mid   = 4'd0;
      bus_if.req_write = 1'b0;
      bus_if.req_addr  = 32'd0;
      bus_if.req_wdata = 32'd0;
      test_reset();
      test_core_release();
      test_readback();
      test_default();
      test_apu();
      test_perm();
      test_dpu();
      test_back_to_back();
      test_uart_robust();
      test_poreset();
      repeat (10) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
